// File: rtl/calc_new_param_if.sv
// Handshake and data bundle between the data-fetch stage, calc_new_param
// and the stack-push/controller stage.
interface calc_new_param_if #(
  parameter int W  = 8,
  parameter int AW = 12
);
  // upstream side
  logic          in_valid;
  logic          in_ready;
  logic [4:0]    position;
  logic [AW-1:0] addr;
  logic [W-1:0]  i_in;
  logic [W-1:0]  z_in;
  logic [W-1:0]  k_in;
  logic [W-1:0]  l_in;
  logic [W-1:0]  d_i;
  logic [1:0]    read_i;
  logic [W-1:0]  occ_k;
  logic [W-1:0]  occ_l;
  logic [W-1:0]  c_val;
  // downstream side
  logic          out_valid;
  logic          out_ready;
  logic [4:0]    position_out;
  logic [AW-1:0] addr_out;
  logic [W-1:0]  i_out;
  logic [W-1:0]  z_out;
  logic [W-1:0]  k_out;
  logic [W-1:0]  l_out;
  logic          push;
  logic          prune;
  logic          hit;

  // the stage itself
  modport slave (
    input  in_valid, position, addr, i_in, z_in, k_in, l_in, d_i, read_i,
           occ_k, occ_l, c_val, out_ready,
    output in_ready, out_valid, position_out, addr_out, i_out, z_out,
           k_out, l_out, push, prune, hit
  );

  // whoever drives the stage and consumes its results
  modport master (
    output in_valid, position, addr, i_in, z_in, k_in, l_in, d_i, read_i,
           occ_k, occ_l, c_val, out_ready,
    input  in_ready, out_valid, position_out, addr_out, i_out, z_out,
           k_out, l_out, push, prune, hit
  );
endinterface

// File: rtl/calc_new_param.sv
// Successor-state computation for the inexact-match search pipeline.
// Stage 1 registers the state and forms the widened interval sums,
// stage 2 registers the successor state and the push/prune/hit decision.
module calc_new_param #(
  parameter int W  = 8,
  parameter int AW = 12
) (
  input logic              clk,
  input logic              rst,
  calc_new_param_if.slave  bus
);

  // position codes: bases ordered A, C, G, T inside each group
  localparam logic [4:0] POS_NONE        = 5'd0;
  localparam logic [4:0] POS_A_INSERTION = 5'd1;
  localparam logic [4:0] POS_T_INSERTION = 5'd4;
  localparam logic [4:0] POS_A_DELETION  = 5'd5;
  localparam logic [4:0] POS_T_DELETION  = 5'd8;

  logic          s1_valid_reg;
  logic [4:0]    s1_pos_reg;
  logic [AW-1:0] s1_addr_reg;
  logic [W-1:0]  s1_i_reg;
  logic [W-1:0]  s1_z_reg;
  logic [W-1:0]  s1_k_reg;
  logic [W-1:0]  s1_l_reg;
  logic [W-1:0]  s1_d_reg;
  logic [1:0]    s1_read_reg;
  logic [W:0]    s1_k_sum_reg;
  logic [W:0]    s1_l_sum_reg;

  logic          out_valid_reg;
  logic [4:0]    pos_out_reg;
  logic [AW-1:0] addr_out_reg;
  logic [W-1:0]  i_out_reg;
  logic [W-1:0]  z_out_reg;
  logic [W-1:0]  k_out_reg;
  logic [W-1:0]  l_out_reg;
  logic          push_reg;
  logic          prune_reg;
  logic          hit_reg;

  logic [W-1:0]  i_next;
  logic [W-1:0]  z_next;
  logic [W-1:0]  k_next;
  logic [W-1:0]  l_next;
  logic          push_next;
  logic          prune_next;
  logic          hit_next;

  logic          s2_move;
  logic          in_ready;
  logic          is_ins;
  logic          is_del;
  logic [4:0]    del_off;
  logic          del_dec;
  logic          empty_iv;

  // stage 2 advances when empty or when its beat is being consumed
  assign s2_move  = !out_valid_reg || bus.out_ready;
  assign in_ready = !s1_valid_reg || s2_move;

  assign is_ins   = (s1_pos_reg >= POS_A_INSERTION) && (s1_pos_reg <= POS_T_INSERTION);
  assign is_del   = (s1_pos_reg >= POS_A_DELETION) && (s1_pos_reg <= POS_T_DELETION);
  assign del_off  = s1_pos_reg - POS_A_DELETION;
  // a deletion keeps z only when the read base equals the edit base
  assign del_dec  = (s1_read_reg != del_off[1:0]);
  // interval is empty if the bounds cross or either bound overflowed W bits
  assign empty_iv = s1_k_sum_reg[W] || s1_l_sum_reg[W] || (s1_k_sum_reg > s1_l_sum_reg);

  // stage 1: capture the state and form the widened interval sums
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
    end else if (in_ready) begin
      s1_valid_reg <= bus.in_valid;
      if (bus.in_valid) begin
        s1_pos_reg   <= bus.position;
        s1_addr_reg  <= bus.addr;
        s1_i_reg     <= bus.i_in;
        s1_z_reg     <= bus.z_in;
        s1_k_reg     <= bus.k_in;
        s1_l_reg     <= bus.l_in;
        s1_d_reg     <= bus.d_i;
        s1_read_reg  <= bus.read_i;
        s1_k_sum_reg <= {1'b0, bus.c_val} + {1'b0, bus.occ_k} + {{W{1'b0}}, 1'b1};
        s1_l_sum_reg <= {1'b0, bus.c_val} + {1'b0, bus.occ_l};
      end
    end
  end

  // successor state and decision; z never wraps below zero
  always_comb begin
    i_next     = s1_i_reg;
    z_next     = s1_z_reg;
    k_next     = s1_k_reg;
    l_next     = s1_l_reg;
    push_next  = 1'b0;
    prune_next = 1'b0;
    hit_next   = 1'b0;
    if (s1_pos_reg == POS_NONE) begin
      if (s1_z_reg < s1_d_reg) prune_next = 1'b1;
      else                     push_next  = 1'b1;
    end else if (is_ins) begin
      k_next = s1_k_sum_reg[W-1:0];
      l_next = s1_l_sum_reg[W-1:0];
      if (s1_z_reg != '0) z_next = s1_z_reg - {{(W-1){1'b0}}, 1'b1};
      if ((s1_z_reg == '0) || empty_iv) prune_next = 1'b1;
      else                              push_next  = 1'b1;
    end else if (is_del) begin
      i_next = s1_i_reg - {{(W-1){1'b0}}, 1'b1};
      if (del_dec && (s1_z_reg != '0)) z_next = s1_z_reg - {{(W-1){1'b0}}, 1'b1};
      if (s1_i_reg == '0) begin
        hit_next = 1'b1;
      end else begin
        k_next = s1_k_sum_reg[W-1:0];
        l_next = s1_l_sum_reg[W-1:0];
        if ((del_dec && (s1_z_reg == '0)) || empty_iv) prune_next = 1'b1;
        else                                           push_next  = 1'b1;
      end
    end
  end

  // stage 2: register the result, hold it while downstream stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      pos_out_reg   <= '0;
      addr_out_reg  <= '0;
      i_out_reg     <= '0;
      z_out_reg     <= '0;
      k_out_reg     <= '0;
      l_out_reg     <= '0;
      push_reg      <= 1'b0;
      prune_reg     <= 1'b0;
      hit_reg       <= 1'b0;
    end else if (s2_move) begin
      out_valid_reg <= s1_valid_reg;
      pos_out_reg   <= s1_pos_reg;
      addr_out_reg  <= s1_addr_reg;
      i_out_reg     <= i_next;
      z_out_reg     <= z_next;
      k_out_reg     <= k_next;
      l_out_reg     <= l_next;
      push_reg      <= push_next && s1_valid_reg;
      prune_reg     <= prune_next && s1_valid_reg;
      hit_reg       <= hit_next && s1_valid_reg;
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = out_valid_reg;
  assign bus.position_out = pos_out_reg;
  assign bus.addr_out     = addr_out_reg;
  assign bus.i_out        = i_out_reg;
  assign bus.z_out        = z_out_reg;
  assign bus.k_out        = k_out_reg;
  assign bus.l_out        = l_out_reg;
  assign bus.push         = push_reg;
  assign bus.prune        = prune_reg;
  assign bus.hit          = hit_reg;

endmodule
